// File: rtl/membus_arbiter_pkg.sv
// Shared bus definitions for the bexkat1 memory arbiter:
// arbiter states, grant encodings and Wishbone constants.
package bexkat1_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT0  = 2'd1,
        ARB_GNT1  = 2'd2,
        ARB_ABORT = 2'd3
    } arb_state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_DAT  = 2'b01;
    localparam logic [1:0] GRANT_INS  = 2'b10;

    localparam logic [3:0] SEL_ALL = 4'hf;

endpackage

// File: rtl/membus_arbiter.sv
// Two-master Wishbone arbiter: data master M0 has priority,
// fetch master M1 is protected from starvation, with a bus watchdog.
module membus_arbiter
    import bexkat1_bus_pkg::*;
#(
    parameter int unsigned MAX_CONSEC = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic [31:0] m1_adr_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  grant_o
);

    localparam int CW = $clog2(MAX_CONSEC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] CONSEC_MAX = CW'(MAX_CONSEC);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    arb_state_e    state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [CW-1:0] consec_q, consec_d;
    logic [TW-1:0] tmo_q, tmo_d;

    // Next-state: arbitration in IDLE, bus lock and watchdog in GNTx
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        consec_d = consec_q;
        tmo_d    = tmo_q;
        unique case (state_q)
            ARB_IDLE: begin
                tmo_d = '0;
                if (m0_cyc_i &&
                    (!m1_cyc_i || consec_q != CONSEC_MAX)) begin
                    state_d  = ARB_GNT0;
                    grant_d  = GRANT_DAT;
                    consec_d = m1_cyc_i ? consec_q + CW'(1) : '0;
                end else if (m1_cyc_i) begin
                    state_d  = ARB_GNT1;
                    grant_d  = GRANT_INS;
                    consec_d = '0;
                end
            end
            ARB_GNT0, ARB_GNT1: begin
                if (!s_cyc_o) begin
                    state_d = ARB_IDLE;
                    grant_d = GRANT_NONE;
                    tmo_d   = '0;
                end else if (s_ack_i) begin
                    tmo_d = '0;
                end else if (s_stb_o) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d = ARB_ABORT;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            ARB_ABORT: begin
                state_d = ARB_IDLE;
                grant_d = GRANT_NONE;
                tmo_d   = '0;
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = GRANT_NONE;
                tmo_d   = '0;
            end
        endcase
    end

    // State, owner and counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ARB_IDLE;
            grant_q  <= GRANT_NONE;
            consec_q <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            consec_q <= consec_d;
            tmo_q    <= tmo_d;
        end
    end

    // Slave-side mux and owner-only ack/err routing
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = 4'h0;
        s_adr_o  = 32'h0;
        s_dat_o  = 32'h0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        unique case (state_q)
            ARB_GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i;
            end
            ARB_GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_sel_o  = SEL_ALL;
                s_adr_o  = m1_adr_i;
                m1_ack_o = s_ack_i;
            end
            ARB_ABORT: begin
                m0_err_o = grant_q[0];
                m1_err_o = grant_q[1];
            end
            default: begin
                s_cyc_o = 1'b0;
            end
        endcase
    end

    assign m0_dat_o = m0_ack_o ? s_dat_i : 32'h0;
    assign m1_dat_o = m1_ack_o ? s_dat_i : 32'h0;
    assign grant_o  = grant_q;

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter: cycle-vector table plus
// starvation, watchdog, race and reset sequences.
module tb_membus_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i;
    logic [31:0] m1_adr_i, m1_dat_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_ack_i;
    logic [1:0]  grant_o;

    always #5 clk = ~clk;

    membus_arbiter #(.MAX_CONSEC(4), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
        .m1_adr_i(m1_adr_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive inputs just after a rising edge, then wait for the
    // falling edge where outputs are sampled.
    task automatic step(input logic c0, input logic s0,
                        input logic c1, input logic s1,
                        input logic ack);
        @(posedge clk);
        #1;
        m0_cyc_i = c0;
        m0_stb_i = s0;
        m1_cyc_i = c1;
        m1_stb_i = s1;
        s_ack_i  = ack;
        @(negedge clk);
    endtask

    typedef struct {
        string       nm;
        logic        c0, s0, c1, s1, ack;
        logic [1:0]  gnt;
        logic        scyc, sstb, swe;
        logic [3:0]  sel;
        logic [31:0] adr, sdat;
        logic        a0, a1;
    } vec_t;

    function automatic vec_t mk(
        input string nm,
        input logic c0, input logic s0,
        input logic c1, input logic s1, input logic ack,
        input logic [1:0] gnt,
        input logic scyc, input logic sstb, input logic swe,
        input logic [3:0] sel,
        input logic [31:0] adr, input logic [31:0] sdat,
        input logic a0, input logic a1);
        vec_t v;
        v.nm = nm; v.c0 = c0; v.s0 = s0; v.c1 = c1;
        v.s1 = s1; v.ack = ack; v.gnt = gnt;
        v.scyc = scyc; v.sstb = sstb; v.swe = swe;
        v.sel = sel; v.adr = adr; v.sdat = sdat;
        v.a0 = a0; v.a1 = a1;
        return v;
    endfunction

    localparam logic [31:0] RDAT = 32'hcafef00d;
    localparam logic [31:0] WDAT = 32'hdeadbeef;
    localparam logic [31:0] A0   = 32'h0000_2000;
    localparam logic [31:0] A1   = 32'h0000_0100;

    vec_t vecs[12];
    logic [1:0] exp_g[6];

    initial begin
        rst_i    = 1'b1;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m0_we_i  = 1'b1; m0_sel_i = 4'h3;
        m0_adr_i = A0;   m0_dat_i = WDAT;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        m1_adr_i = A1;
        s_dat_i  = RDAT; s_ack_i = 1'b0;

        // Each row: inputs for this cycle, outputs expected in it
        vecs[0]  = mk("m1_idle",   0,0,1,1,0, 2'b00,
                      0,0,0, 4'h0, 32'h0, 32'h0, 0,0);
        vecs[1]  = mk("m1_beat",   0,0,1,1,1, 2'b10,
                      1,1,0, 4'hf, A1, 32'h0, 0,1);
        vecs[2]  = mk("m1_drop",   0,0,0,0,0, 2'b10,
                      0,0,0, 4'hf, A1, 32'h0, 0,0);
        vecs[3]  = mk("idle_a",    0,0,0,0,0, 2'b00,
                      0,0,0, 4'h0, 32'h0, 32'h0, 0,0);
        vecs[4]  = mk("both_req",  1,1,1,1,0, 2'b00,
                      0,0,0, 4'h0, 32'h0, 32'h0, 0,0);
        vecs[5]  = mk("m0_beat",   1,1,1,1,1, 2'b01,
                      1,1,1, 4'h3, A0, WDAT, 1,0);
        vecs[6]  = mk("m0_drop",   0,0,1,1,0, 2'b01,
                      0,0,1, 4'h3, A0, WDAT, 0,0);
        vecs[7]  = mk("turnaround",0,0,1,1,0, 2'b00,
                      0,0,0, 4'h0, 32'h0, 32'h0, 0,0);
        vecs[8]  = mk("m1_wait",   0,0,1,1,0, 2'b10,
                      1,1,0, 4'hf, A1, 32'h0, 0,0);
        vecs[9]  = mk("m1_after",  0,0,1,1,1, 2'b10,
                      1,1,0, 4'hf, A1, 32'h0, 0,1);
        vecs[10] = mk("m1_end",    0,0,0,0,0, 2'b10,
                      0,0,0, 4'hf, A1, 32'h0, 0,0);
        vecs[11] = mk("idle_b",    0,0,0,0,0, 2'b00,
                      0,0,0, 4'h0, 32'h0, 32'h0, 0,0);

        exp_g[0] = 2'b01; exp_g[1] = 2'b01;
        exp_g[2] = 2'b01; exp_g[3] = 2'b01;
        exp_g[4] = 2'b10; exp_g[5] = 2'b01;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_scyc",  32'(s_cyc_o), 32'h0);
        chk("rst_sstb",  32'(s_stb_o), 32'h0);
        chk("rst_acks",  32'({m0_ack_o, m1_ack_o}), 32'h0);
        chk("rst_errs",  32'({m0_err_o, m1_err_o}), 32'h0);
        rst_i = 1'b0;

        // Cycle-vector table
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].c0, vecs[i].s0, vecs[i].c1,
                 vecs[i].s1, vecs[i].ack);
            chk({vecs[i].nm, ".grant"}, 32'(grant_o),
                32'(vecs[i].gnt));
            chk({vecs[i].nm, ".scyc"}, 32'(s_cyc_o),
                32'(vecs[i].scyc));
            chk({vecs[i].nm, ".sstb"}, 32'(s_stb_o),
                32'(vecs[i].sstb));
            chk({vecs[i].nm, ".swe"}, 32'(s_we_o),
                32'(vecs[i].swe));
            chk({vecs[i].nm, ".sel"}, 32'(s_sel_o),
                32'(vecs[i].sel));
            chk({vecs[i].nm, ".adr"}, s_adr_o, vecs[i].adr);
            chk({vecs[i].nm, ".sdat"}, s_dat_o, vecs[i].sdat);
            chk({vecs[i].nm, ".ack0"}, 32'(m0_ack_o),
                32'(vecs[i].a0));
            chk({vecs[i].nm, ".ack1"}, 32'(m1_ack_o),
                32'(vecs[i].a1));
            chk({vecs[i].nm, ".dat0"}, m0_dat_o,
                vecs[i].a0 ? RDAT : 32'h0);
            chk({vecs[i].nm, ".dat1"}, m1_dat_o,
                vecs[i].a1 ? RDAT : 32'h0);
        end

        // Starvation guard: M1 waits through M0 transfers
        for (int t = 0; t < 6; t++) begin
            step(1,1,1,1,0);
            chk($sformatf("starve%0d.idle", t),
                32'(grant_o), 32'h0);
            step(1,1,1,1,1);
            chk($sformatf("starve%0d.grant", t),
                32'(grant_o), 32'(exp_g[t]));
            if (grant_o == 2'b10)
                step(1,1,0,0,0);
            else
                step(0,0,1,1,0);
        end
        step(0,0,0,0,0);

        // Watchdog: slave never acks an M0 write
        step(1,1,0,0,0);
        chk("tmo.idle", 32'(grant_o), 32'h0);
        for (int i = 1; i <= 8; i++) begin
            step(1,1,0,0,0);
            chk($sformatf("tmo.wait%0d.scyc", i),
                32'(s_cyc_o), 32'h1);
            chk($sformatf("tmo.wait%0d.err", i),
                32'(m0_err_o), 32'h0);
        end
        step(1,1,0,0,1);
        chk("tmo.abort.scyc", 32'(s_cyc_o), 32'h0);
        chk("tmo.abort.sstb", 32'(s_stb_o), 32'h0);
        chk("tmo.abort.err0", 32'(m0_err_o), 32'h1);
        chk("tmo.abort.err1", 32'(m1_err_o), 32'h0);
        chk("tmo.abort.ack0", 32'(m0_ack_o), 32'h0);
        step(0,0,0,0,0);
        chk("tmo.after.err0", 32'(m0_err_o), 32'h0);
        chk("tmo.after.grant", 32'(grant_o), 32'h0);

        // Ack on the cycle the count reaches the limit
        step(1,1,0,0,0);
        for (int i = 1; i <= 7; i++) step(1,1,0,0,0);
        step(1,1,0,0,1);
        chk("race_ack.ack0", 32'(m0_ack_o), 32'h1);
        chk("race_ack.dat0", m0_dat_o, RDAT);
        chk("race_ack.err0", 32'(m0_err_o), 32'h0);
        step(0,0,0,0,0);
        chk("race_ack.next.grant", 32'(grant_o), 32'h1);
        chk("race_ack.next.err0", 32'(m0_err_o), 32'h0);
        step(0,0,0,0,0);
        chk("race_ack.idle.err0", 32'(m0_err_o), 32'h0);

        // Owner drops cyc on the cycle the count reaches the limit
        step(1,1,0,0,0);
        for (int i = 1; i <= 7; i++) step(1,1,0,0,0);
        step(0,0,0,0,0);
        chk("race_drop.err0", 32'(m0_err_o), 32'h0);
        step(0,0,0,0,0);
        chk("race_drop.idle.err0", 32'(m0_err_o), 32'h0);
        chk("race_drop.idle.grant", 32'(grant_o), 32'h0);

        // Reset in the middle of an M1 beat
        step(0,0,1,1,0);
        step(0,0,1,1,0);
        chk("rst_mid.pre.grant", 32'(grant_o), 32'h2);
        rst_i = 1'b1;
        step(0,0,1,1,1);
        chk("rst_mid.scyc", 32'(s_cyc_o), 32'h0);
        chk("rst_mid.sstb", 32'(s_stb_o), 32'h0);
        chk("rst_mid.sel",  32'(s_sel_o), 32'h0);
        chk("rst_mid.adr",  s_adr_o, 32'h0);
        chk("rst_mid.grant", 32'(grant_o), 32'h0);
        chk("rst_mid.ack1", 32'(m1_ack_o), 32'h0);
        rst_i = 1'b0;
        step(0,0,1,1,1);
        chk("rst_rel.grant", 32'(grant_o), 32'h2);
        chk("rst_rel.ack1", 32'(m1_ack_o), 32'h1);
        chk("rst_rel.dat1", m1_dat_o, RDAT);
        step(0,0,0,0,0);
        step(0,0,0,0,0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
